fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction-fetch front end that consumes the execute stage's redirect output (`next_pc` plus a taken flag) and turns it into an instruction stream for decode. It owns the architectural PC and issues one-outstanding-request reads to a variable-latency instruction memory. Returned instructions go into a 2-entry buffer that decode drains under its own stall. On a redirect from execute it flushes wrong-path work, including a read already in flight.

## Interface
Parameters:
- `RESET_PC`, 16'h0000: PC loaded on reset.
- `BUF_DEPTH`, 2: instruction buffer entries. Fixed at 2; other values are not supported.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `redirect`  in  1  execute resolved a taken branch, jump or JR; `redirect_pc` is valid.
- `redirect_pc`  in  16  next PC computed by execute.
- `halt`  in  1  decode has consumed a HALT; stop fetching.
- `imem_req`  out  1  read request; held high until `imem_ack`.
- `imem_addr`  out  16  read address; stable while `imem_req` is high.
- `imem_ack`  in  1  one-cycle pulse; `imem_data` is valid this cycle.
- `imem_data`  in  16  instruction word.
- `id_stall`  in  1  decode cannot accept an instruction this cycle.
- `if_valid`  out  1  buffer head holds a valid instruction.
- `if_instr`  out  16  instruction at the buffer head.
- `if_pc`  out  16  address of `if_instr`.
- `if_pc2`  out  16  `if_pc` + 2; execute uses it as the PC for branch arithmetic.

## Operation
- State machine: RUN, HALTED. Reset enters RUN.
- Registers:
  - `pc`: next address to issue.
  - `req_active`: a request is outstanding.
  - `squash`: the outstanding request is wrong-path.
  - `count`: buffer occupancy, 0..2.
  - buffer entries, each an {instr, pc} pair.
- Consume: `if_valid & ~id_stall` at an edge pops the head. Entries leave in FIFO order.
- Push: `imem_ack & ~squash` with no redirect and no halt writes {`imem_data`, `imem_addr`} at the tail.
- Issue: in RUN, a request is raised at an edge when `count_after_edge + (req_still_active) < 2`.
  - `count_after_edge` includes that edge's push and pop.
  - At issue, `imem_addr` ← `pc` and `pc` ← `pc` + 2 (16-bit wrap: 16'hFFFE → 16'h0000).
  - If an ack and a re-issue happen on the same edge, `imem_req` stays high with the new address. This allows one instruction per cycle.
- Priority at each edge is redirect > halt > normal.
  - **Redirect:**
    - `count` ← 0.
    - `pc` ← `redirect_pc`.
    - State ← RUN; a redirect exits HALTED.
    - If a request is outstanding and not acked this edge, set `squash`. The request stays high until its ack, that data is dropped, then `squash` clears.
    - If acked this edge, the data is dropped.
    - The first request to the target is raised at the edge after `req_active` clears. When no request is outstanding, that is the redirect edge itself.
  - **Halt:**
    - State ← HALTED and `count` ← 0.
    - An outstanding request completes and its data is dropped.
    - No new requests are issued.
  - **Simultaneous `redirect` and `halt`:** the HALT is wrong-path; take the redirect.
- `if_pc2` is combinational from the head entry's pc, wrapping modulo 2^16.
- `imem_data` is never interpreted.

## Timing
- Reset (asynchronous assert):
  - `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_instr`=0, `if_pc`=0, `if_pc2`=2.
  - `pc`=`RESET_PC`, `count`=0, `squash`=0, state RUN.
- First edge after `rst` deasserts: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Ack at edge k: `if_valid`=1 from cycle k+1, when the buffer was empty.
- Redirect at edge r with no request outstanding:
  - `imem_req` to the target from cycle r+1.
  - The target instruction is visible the cycle after its ack.
- `if_valid` falls on the edge of a redirect or halt, regardless of `id_stall`.
- Reset asserted mid-request: the request is abandoned immediately. The memory must tolerate `imem_req` dropping before ack.
- A full buffer with `id_stall`=1 holds every output stable. No request is issued, so none can be lost.

## Test plan
- Reset release with an ack the cycle after each request:
  - `imem_addr` goes 0000, 0002, 0004.
  - `if_valid` is high continuously from cycle 2.
  - `if_pc2` = `if_pc` + 2.
- `id_stall` held high while acks arrive:
  - Exactly 2 entries are buffered and `imem_req` drops.
  - On release, 0000 then 0002 are delivered in order and the next request goes to 0004.
- Memory latency 3; redirect to 0x0100 one cycle after the request to 0x0008 is issued:
  - The ack data for 0x0008 is dropped.
  - The next `imem_addr` is 0x0100.
  - The first delivered `if_pc` is 0x0100.
- Redirect and ack on the same edge: the data is dropped, `count` is 0, and the next request goes to `redirect_pc`.
- `halt` with 1 entry buffered:
  - `if_valid` falls and no further `imem_req` is raised.
  - A later redirect to 0x0040 resumes fetch at 0x0040.
- `pc` at 0xFFFE: the next issued address is 0x0000. `rst` pulsed low mid-request: all outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch front end: owns the PC, issues single-outstanding reads to
// instruction memory and buffers up to two returned {instr, pc} pairs for decode.
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    input  logic        id_stall,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc2
);

    typedef enum logic {RUN, HALTED} state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } entry_t;

    localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

    state_t      state;
    logic [15:0] pc;
    logic        squash;
    logic [1:0]  count;
    entry_t      ent0;
    entry_t      ent1;

    logic        ack;
    logic        push;
    logic        pop;
    logic [1:0]  count_nx;
    logic        can_issue;
    entry_t      new_entry;

    // A stray ack with no request outstanding is ignored.
    assign ack       = imem_ack & imem_req;
    assign push      = ack & ~squash;
    assign pop       = (count != 2'd0) & ~id_stall;
    assign count_nx  = count + 2'(push) - 2'(pop);
    assign new_entry = '{instr: imem_data, pc: imem_addr};

    // A good ack frees the port this edge; a squashed ack only frees it for the next edge.
    assign can_issue = (state == RUN) & (~imem_req | push) & (count_nx < DEPTH);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            pc        <= RESET_PC;
            squash    <= 1'b0;
            count     <= 2'd0;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            // NOTE: the buffer entries are reset because the head drives the
            // if_* outputs directly and those have defined reset values.
            ent0      <= '0;
            ent1      <= '0;
        end else if (redirect) begin
            state <= RUN;
            count <= 2'd0;
            if (!imem_req) begin
                imem_req  <= 1'b1;
                imem_addr <= redirect_pc;
                pc        <= redirect_pc + 16'd2;
            end else begin
                pc <= redirect_pc;
                if (ack) begin
                    imem_req <= 1'b0;
                    squash   <= 1'b0;
                end else begin
                    squash <= 1'b1;
                end
            end
        end else if (halt) begin
            state <= HALTED;
            count <= 2'd0;
            if (ack) begin
                imem_req <= 1'b0;
                squash   <= 1'b0;
            end else if (imem_req) begin
                squash <= 1'b1;
            end
        end else begin
            count <= count_nx;
            // Head lives in ent0; a pop shifts ent1 forward.
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= new_entry;
                    else               ent1 <= new_entry;
                end
                2'b01: ent0 <= ent1;
                2'b11: begin
                    if (count == 2'd1) begin
                        ent0 <= new_entry;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= new_entry;
                    end
                end
                default: ;
            endcase
            if (ack) squash <= 1'b0;
            if (can_issue) begin
                imem_req  <= 1'b1;
                imem_addr <= pc;
                pc        <= pc + 16'd2;
            end else if (ack) begin
                imem_req <= 1'b0;
            end
        end
    end

    assign if_valid = (count != 2'd0);
    assign if_instr = ent0.instr;
    assign if_pc    = ent0.pc;
    assign if_pc2   = ent0.pc + 16'd2;

endmodule
